// File: rtl/apb_master_ctrl.sv
// APB master stage: turns single-beat valid/ready commands into APB SETUP/ACCESS
// transfers and returns read data/status on a valid/ready response channel.
// Optional feature: define APB_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES.
module apb_master_ctrl #(
    parameter int BANK_ADDR      = 2,
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 3
`ifdef APB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 16
`endif
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [BANK_ADDR-1:0]  cmd_sel,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [BANK_ADDR-1:0]  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pwdata,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_RESP
    } state_t;

    state_t                  r_state;
    logic                    r_cmd_ready;
    logic                    r_rsp_valid;
    logic [DATA_WIDTH-1:0]   r_rsp_rdata;
    logic                    r_rsp_err;
    logic [BANK_ADDR-1:0]    r_psel;
    logic                    r_penable;
    logic                    r_pwrite;
    logic [ADDR_WIDTH-1:0]   r_paddr;
    logic [DATA_WIDTH-1:0]   r_pwdata;

`ifdef APB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    logic [CNT_W-1:0]        r_timeout_cnt;
`endif

    // NOTE: state and outputs are all registered with non-blocking assignments, and
    // the synchronous reset has priority so a reset mid-transfer releases the bus.
    always_ff @(posedge pclk) begin
        if (preset) begin
            r_state     <= S_IDLE;
            r_cmd_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_psel      <= '0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
`ifdef APB_TIMEOUT_EN
            r_timeout_cnt <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid && r_cmd_ready) begin
                        r_cmd_ready <= 1'b0;
                        if (cmd_sel == '0) begin
                            // No bank selected: answer with an error, never touch the bus.
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_rsp_rdata <= '0;
                            r_state     <= S_RESP;
                        end else begin
                            r_psel   <= cmd_sel;
                            r_pwrite <= cmd_write;
                            r_paddr  <= cmd_addr;
                            r_pwdata <= cmd_wdata;
                            r_state  <= S_SETUP;
                        end
                    end else begin
                        r_cmd_ready <= 1'b1;
                    end
                end

                S_SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= S_ACCESS;
`ifdef APB_TIMEOUT_EN
                    r_timeout_cnt <= '0;
`endif
                end

                S_ACCESS: begin
                    if (pready) begin
                        r_psel      <= '0;
                        r_penable   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b0;
                        r_rsp_rdata <= r_pwrite ? '0 : prdata;
                        r_state     <= S_RESP;
                    end
`ifdef APB_TIMEOUT_EN
                    // pready is tested first, so a late ready on the last counted cycle wins.
                    else if (r_timeout_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        r_psel      <= '0;
                        r_penable   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b1;
                        r_rsp_rdata <= '0;
                        r_state     <= S_RESP;
                    end else begin
                        r_timeout_cnt <= r_timeout_cnt + 1'b1;
                    end
`endif
                end

                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign psel      = r_psel;
    assign penable   = r_penable;
    assign pwrite    = r_pwrite;
    assign paddr     = r_paddr;
    assign pwdata    = r_pwdata;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Directed self-checking bench for apb_master_ctrl; outputs sampled 1ns after each
// rising edge, inputs driven at the same point. Covers APB_TIMEOUT_EN both ways.
module tb_apb_master_ctrl;

    localparam int BW = 2;
    localparam int DW = 8;
    localparam int AW = 3;

    logic          pclk = 1'b0;
    logic          preset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [BW-1:0] cmd_sel;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic [BW-1:0] psel;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [DW-1:0] prdata;
    logic          pready;

    int n_checks = 0;
    int n_fail   = 0;

    apb_master_ctrl dut (
        .pclk      (pclk),
        .preset    (preset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_sel   (cmd_sel),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .pready    (pready)
    );

    always #5 pclk = ~pclk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    // Present one command for exactly one edge; caller guarantees cmd_ready is high.
    task automatic issue(input logic wr, input logic [BW-1:0] sel,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        cmd_write = wr;
        cmd_sel   = sel;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    // Consume the pending response, then confirm cmd_ready returns one edge later.
    task automatic complete_rsp(input string tag);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check({tag, "_rsp_drop"}, rsp_valid, 1'b0);
        check({tag, "_rdy_low"}, cmd_ready, 1'b0);
        tick();
        check({tag, "_rdy_back"}, cmd_ready, 1'b1);
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        preset    = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_sel   = '0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b0;
        prdata    = '0;
        pready    = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_psel", psel, 2'b00);
        check("rst_penable", penable, 1'b0);
        check("rst_bus", {pwrite, paddr, pwdata}, 12'h000);
        check("rst_rsp", {rsp_valid, rsp_err, rsp_rdata}, 10'h000);
        check("rst_cmd_ready", cmd_ready, 1'b0);
        preset = 1'b0;
        tick();
        check("post_rst_ready", cmd_ready, 1'b1);

        // 1: write, zero wait states
        pready = 1'b1;
        issue(1'b1, 2'b01, 3'h5, 8'hA5);
        check("t1_setup_psel", psel, 2'b01);
        check("t1_setup_pen", penable, 1'b0);
        check("t1_setup_bus", {pwrite, paddr, pwdata}, {1'b1, 3'h5, 8'hA5});
        check("t1_setup_cmdrdy", cmd_ready, 1'b0);
        tick();
        check("t1_access", {psel, penable, rsp_valid}, {2'b01, 1'b1, 1'b0});
        tick();
        check("t1_rsp", {rsp_valid, rsp_err, rsp_rdata}, {1'b1, 1'b0, 8'h00});
        check("t1_release", {psel, penable}, 3'b000);
        complete_rsp("t1");

        // 2: read, zero wait states
        prdata = 8'hF9;
        issue(1'b0, 2'b10, 3'h2, 8'h00);
        check("t2_setup", {psel, penable, pwrite, paddr}, {2'b10, 1'b0, 1'b0, 3'h2});
        tick();
        check("t2_access", {psel, penable}, {2'b10, 1'b1});
        tick();
        check("t2_rsp", {rsp_valid, rsp_err, rsp_rdata}, {1'b1, 1'b0, 8'hF9});
        check("t2_release", {psel, penable}, 3'b000);
        complete_rsp("t2");

        // 3: read with 5 wait states; cmd_* wiggled mid-transfer must be ignored
        pready = 1'b0;
        prdata = 8'h3C;
        issue(1'b0, 2'b01, 3'h6, 8'h00);
        tick();
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_sel   = 2'b10;
        cmd_addr  = 3'h1;
        cmd_wdata = 8'h77;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t3_wait%0d", i), {penable, psel, pwrite, paddr, rsp_valid},
                  {1'b1, 2'b01, 1'b0, 3'h6, 1'b0});
            tick();
        end
        check("t3_sixth", {penable, paddr, rsp_valid}, {1'b1, 3'h6, 1'b0});
        cmd_valid = 1'b0;
        pready    = 1'b1;
        tick();
        pready = 1'b0;
        check("t3_rsp", {rsp_valid, rsp_err, rsp_rdata}, {1'b1, 1'b0, 8'h3C});
        complete_rsp("t3");

        // 4: cmd_sel == 0 -> immediate error response, no bus activity
        prdata = 8'hEE;
        issue(1'b0, 2'b00, 3'h3, 8'h00);
        check("t4_rsp", {rsp_valid, rsp_err, rsp_rdata}, {1'b1, 1'b1, 8'h00});
        check("t4_nobus", {psel, penable}, 3'b000);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("t4_hold%0d", i), {rsp_valid, rsp_err, psel, penable},
                  {1'b1, 1'b1, 2'b00, 1'b0});
        end
        complete_rsp("t4");

        // 5: reset during ACCESS
        issue(1'b1, 2'b10, 3'h4, 8'h5A);
        tick();
        check("t5_in_access", penable, 1'b1);
        preset = 1'b1;
        tick();
        check("t5_abort", {psel, penable, rsp_valid, cmd_ready}, 5'b00000);
        preset = 1'b0;
        pready = 1'b1;
        tick();
        check("t5_ready_back", {cmd_ready, rsp_valid, psel}, {1'b1, 1'b0, 2'b00});
        prdata = 8'h81;
        issue(1'b0, 2'b01, 3'h7, 8'h00);
        tick();
        tick();
        check("t5_recover", {rsp_valid, rsp_err, rsp_rdata}, {1'b1, 1'b0, 8'h81});
        complete_rsp("t5");

        // 6: pready stuck low
        pready = 1'b0;
        prdata = 8'h42;
        issue(1'b0, 2'b01, 3'h1, 8'h00);
        tick();
`ifdef APB_TIMEOUT_EN
        for (int i = 0; i < 15; i++) tick();
        check("t6_before_to", {penable, rsp_valid}, 2'b10);
        tick();
        check("t6_timeout", {rsp_valid, rsp_err, rsp_rdata}, {1'b1, 1'b1, 8'h00});
        check("t6_to_release", {psel, penable}, 3'b000);
        complete_rsp("t6");

        // Ready on the 16th ACCESS edge beats the timeout
        issue(1'b0, 2'b10, 3'h2, 8'h00);
        tick();
        for (int i = 0; i < 15; i++) tick();
        pready = 1'b1;
        tick();
        pready = 1'b0;
        check("t6_late_ready", {rsp_valid, rsp_err, rsp_rdata}, {1'b1, 1'b0, 8'h42});
        complete_rsp("t6b");
`else
        for (int i = 0; i < 100; i++) tick();
        check("t6_still_waiting", {psel, penable, rsp_valid}, {2'b01, 1'b1, 1'b0});
        pready = 1'b1;
        tick();
        pready = 1'b0;
        check("t6_finally", {rsp_valid, rsp_err, rsp_rdata}, {1'b1, 1'b0, 8'h42});
        complete_rsp("t6");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
